instr_sequencer: RTL and testbench

- Parameterised instruction fetch/decode timing sequencer for the CPU system.
- Generates the one-hot timing signal T and fetches a multi-byte instruction from byte-wide memory, with a memory-ready wait-state handshake.
- Latches the instruction register and opcode, then hands the remaining T states to the execute control logic.
- Adds behaviour the fixed 12-state ring lacks: variable instruction length, wait states, execute stall, early termination, halt, and overrun detection.

---
 rtl/cpu_seq_pkg.sv | 46 ++++
 rtl/one_hot_timer.sv | 26 ++
 rtl/instr_sequencer.sv | 100 ++++++++++
 tb/tb_instr_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU fetch/decode sequencer and the control unit:
// state-class index helpers, opcode encodings and parameter sanity checks.
package cpu_seq_pkg;

  localparam int BYTE_W = 8;

  // Opcode encodings shared with the execute control unit
  localparam logic [5:0] BRA   = 6'h00;
  localparam logic [5:0] BRZ   = 6'h01;
  localparam logic [5:0] BRN   = 6'h02;
  localparam logic [5:0] JSR   = 6'h03;
  localparam logic [5:0] RTS   = 6'h04;
  localparam logic [5:0] LDA   = 6'h08;
  localparam logic [5:0] LDI   = 6'h09;
  localparam logic [5:0] STA   = 6'h0A;
  localparam logic [5:0] ADDA  = 6'h10;
  localparam logic [5:0] SUBA  = 6'h11;
  localparam logic [5:0] ANDA  = 6'h12;
  localparam logic [5:0] ORA   = 6'h13;
  localparam logic [5:0] XORA  = 6'h14;
  localparam logic [5:0] SHL   = 6'h18;
  localparam logic [5:0] SHR   = 6'h19;
  localparam logic [5:0] LDIM  = 6'h20;
  localparam logic [5:0] STIM  = 6'h21;
  localparam logic [5:0] LDRM  = 6'h22;
  localparam logic [5:0] STRM  = 6'h23;
  localparam logic [5:0] STRIM = 6'h24;

  function automatic int fetch_last_idx(input int instr_bytes);
    return instr_bytes - 1;
  endfunction

  function automatic int decode_idx(input int instr_bytes);
    return instr_bytes;
  endfunction

  function automatic int exec_first_idx(input int instr_bytes);
    return instr_bytes + 1;
  endfunction

  function automatic bit params_ok(input int instr_bytes, input int num_t, input int opcode_w);
    return (instr_bytes >= 1) && (instr_bytes <= 4) && (num_t >= instr_bytes + 2) &&
           (opcode_w >= 1) && (opcode_w <= BYTE_W * instr_bytes);
  endfunction

endpackage

// File: rtl/one_hot_timer.sv
// One-hot timing ring with park (all-zero), restart (T0), hold and advance.
// Priority: park > restart > hold > advance; with no request the state holds.
module one_hot_timer #(
  parameter int NUM_T = 12
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             advance,
  input  logic             hold,
  input  logic             restart,
  input  logic             park,
  output logic [NUM_T-1:0] T,
  output logic             last
);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)        T <= NUM_T'(1);
    else if (park)    T <= '0;
    else if (restart) T <= NUM_T'(1);
    else if (hold)    T <= T;
    else if (advance) T <= {T[NUM_T-2:0], 1'b0};
  end

  assign last = T[NUM_T-1];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction fetch/decode timing sequencer: fetches INSTR_BYTES bytes LSB first
// with a Mem_Ready wait-state handshake, then hands the remaining T states to execute.
module instr_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int INSTR_BYTES = 2,
  parameter int NUM_T       = 12,
  parameter int OPCODE_W    = 6
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [7:0]               Mem_Data,
  input  logic                     Mem_Ready,
  input  logic                     Stall,
  input  logic                     Done,
  input  logic                     Halt,
  output logic [NUM_T-1:0]         T,
  output logic [8*INSTR_BYTES-1:0] IR,
  output logic [OPCODE_W-1:0]      Opcode,
  output logic                     Decode_Valid,
  output logic                     Mem_CS,
  output logic                     PC_Inc,
  output logic                     Halted,
  output logic                     Overrun
);

  localparam int IR_W       = BYTE_W * INSTR_BYTES;
  localparam int FETCH_LAST = fetch_last_idx(INSTR_BYTES);
  localparam int DEC_IDX    = decode_idx(INSTR_BYTES);
  localparam int EXEC_FIRST = exec_first_idx(INSTR_BYTES);

  if (!params_ok(INSTR_BYTES, NUM_T, OPCODE_W)) begin : g_param_err
    $error("instr_sequencer: illegal INSTR_BYTES/NUM_T/OPCODE_W combination");
  end

  logic in_fetch, in_decode, in_exec, last;
  logic advance, hold, restart, park;

  one_hot_timer #(.NUM_T(NUM_T)) u_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (advance),
    .hold    (hold),
    .restart (restart),
    .park    (park),
    .T       (T),
    .last    (last)
  );

  assign in_fetch  = |T[FETCH_LAST:0];
  assign in_decode = T[DEC_IDX];
  assign in_exec   = |T[NUM_T-1:EXEC_FIRST];

  always_comb begin
    advance = 1'b0;
    hold    = 1'b0;
    restart = 1'b0;
    park    = 1'b0;
    if (in_fetch) begin
      advance = Mem_Ready;
      hold    = ~Mem_Ready;
    end else if (in_decode || in_exec) begin
      // Done beats Stall; running off the end wraps unless stalled there
      if (Done || (last && !Stall)) begin
        park    = Halt;
        restart = ~Halt;
      end else if (Stall) begin
        hold = 1'b1;
      end else begin
        advance = 1'b1;
      end
    end else begin
      restart = ~Halt;
      hold    = Halt;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      IR      <= '0;
      Opcode  <= '0;
      Overrun <= 1'b0;
    end else begin
      for (int k = 0; k < INSTR_BYTES; k++) begin
        if (T[k] && Mem_Ready) IR[BYTE_W*k +: BYTE_W] <= Mem_Data;
      end
      if (in_decode) Opcode <= IR[IR_W-1 -: OPCODE_W];
      if (in_exec && last && !Done && !Stall) Overrun <= 1'b1;
    end
  end

  assign Mem_CS       = ~(in_fetch & ~Reset);
  assign PC_Inc       = in_fetch & Mem_Ready & ~Reset;
  assign Decode_Valid = in_decode & ~Reset;
  assign Halted       = ~|T;

  a_t_onehot0: assert property (@(posedge Clock) disable iff (Reset) $onehot0(T))
    else $error("instr_sequencer: T is not one-hot or zero");

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle vector table for the default
// configuration plus hand-written async-reset and INSTR_BYTES=3 sequences.
module tb_instr_sequencer;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, Mem_Ready, Stall, Done, Halt;
  logic [7:0]  Mem_Data;
  logic [11:0] T;
  logic [15:0] IR;
  logic [5:0]  Opcode;
  logic        Decode_Valid, Mem_CS, PC_Inc, Halted, Overrun;

  logic        rst3, mr3, st3, dn3, hl3;
  logic [7:0]  md3;
  logic [11:0] t3;
  logic [23:0] ir3;
  logic [5:0]  op3;
  logic        dv3, cs3, pc3, hd3, ov3;

  instr_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Mem_Data(Mem_Data), .Mem_Ready(Mem_Ready),
    .Stall(Stall), .Done(Done), .Halt(Halt), .T(T), .IR(IR), .Opcode(Opcode),
    .Decode_Valid(Decode_Valid), .Mem_CS(Mem_CS), .PC_Inc(PC_Inc),
    .Halted(Halted), .Overrun(Overrun)
  );

  instr_sequencer #(.INSTR_BYTES(3), .NUM_T(12), .OPCODE_W(6)) dut3 (
    .Clock(Clock), .Reset(rst3), .Mem_Data(md3), .Mem_Ready(mr3),
    .Stall(st3), .Done(dn3), .Halt(hl3), .T(t3), .IR(ir3), .Opcode(op3),
    .Decode_Valid(dv3), .Mem_CS(cs3), .PC_Inc(pc3),
    .Halted(hd3), .Overrun(ov3)
  );

  typedef struct {
    logic        mr;
    logic [7:0]  md;
    logic        st, dn, hl;
    logic [11:0] t;
    logic        pc, cs, dv, hd;
    logic [15:0] ir;
    logic [5:0]  op;
    logic        ov;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic mr, input logic [7:0] md, input logic st,
                              input logic dn, input logic hl, input logic [11:0] t,
                              input logic pc, input logic cs, input logic dv, input logic hd,
                              input logic [15:0] ir, input logic [5:0] op, input logic ov);
    vec_t v;
    v.mr = mr; v.md = md; v.st = st; v.dn = dn; v.hl = hl; v.t = t;
    v.pc = pc; v.cs = cs; v.dv = dv; v.hd = hd; v.ir = ir; v.op = op; v.ov = ov;
    vecs.push_back(v);
  endfunction

  initial begin
    int pc_cnt;

    //   mr  md    st dn hl  T        pc cs dv hd  IR        Op     Ov
    // basic fetch 0x34,0x12 then stall at T5 and Done at T6
    add(1, 8'h34, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'h0000, 6'h00, 0);
    add(1, 8'h12, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'h0034, 6'h00, 0);
    add(0, 8'h00, 0, 0, 0, 12'h004, 0, 1, 1, 0, 16'h1234, 6'h00, 0);
    add(0, 8'h00, 0, 0, 0, 12'h008, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h00, 0, 0, 0, 12'h010, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h00, 1, 0, 0, 12'h020, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h00, 1, 0, 0, 12'h020, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h00, 0, 0, 0, 12'h020, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h00, 0, 1, 0, 12'h040, 0, 1, 0, 0, 16'h1234, 6'h04, 0);
    // wait states at T1, then Done+Stall at T3
    add(1, 8'h78, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'h1234, 6'h04, 0);
    add(0, 8'h99, 0, 0, 0, 12'h002, 0, 0, 0, 0, 16'h1278, 6'h04, 0);
    add(0, 8'h99, 0, 0, 0, 12'h002, 0, 0, 0, 0, 16'h1278, 6'h04, 0);
    add(0, 8'h99, 0, 0, 0, 12'h002, 0, 0, 0, 0, 16'h1278, 6'h04, 0);
    add(1, 8'hAB, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'h1278, 6'h04, 0);
    add(0, 8'h00, 0, 0, 0, 12'h004, 0, 1, 1, 0, 16'hAB78, 6'h04, 0);
    add(0, 8'h00, 1, 1, 0, 12'h008, 0, 1, 0, 0, 16'hAB78, 6'h2A, 0);
    // Done in decode
    add(1, 8'h00, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'hAB78, 6'h2A, 0);
    add(1, 8'h11, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'hAB00, 6'h2A, 0);
    add(0, 8'h00, 0, 1, 0, 12'h004, 0, 1, 1, 0, 16'h1100, 6'h2A, 0);
    // run past T11 with a stall in the last state, then overrun
    add(1, 8'hFF, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'h1100, 6'h04, 0);
    add(1, 8'hFF, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'h11FF, 6'h04, 0);
    add(0, 8'h00, 0, 0, 0, 12'h004, 0, 1, 1, 0, 16'hFFFF, 6'h04, 0);
    add(0, 8'h00, 0, 0, 0, 12'h008, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h010, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h020, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h040, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h080, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h100, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h200, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h400, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 1, 0, 0, 12'h800, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(0, 8'h00, 0, 0, 0, 12'h800, 0, 1, 0, 0, 16'hFFFF, 6'h3F, 0);
    add(1, 8'h21, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'hFFFF, 6'h3F, 1);
    add(1, 8'h43, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'hFF21, 6'h3F, 1);
    add(0, 8'h00, 0, 1, 0, 12'h004, 0, 1, 1, 0, 16'h4321, 6'h3F, 1);
    // halt with Done at T4, resume, then halt raised during fetch
    add(1, 8'h05, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'h4321, 6'h10, 1);
    add(1, 8'h00, 0, 0, 0, 12'h002, 1, 0, 0, 0, 16'h4305, 6'h10, 1);
    add(0, 8'h00, 0, 0, 0, 12'h004, 0, 1, 1, 0, 16'h0005, 6'h10, 1);
    add(0, 8'h00, 0, 0, 0, 12'h008, 0, 1, 0, 0, 16'h0005, 6'h00, 1);
    add(0, 8'h00, 0, 1, 1, 12'h010, 0, 1, 0, 0, 16'h0005, 6'h00, 1);
    add(1, 8'h00, 0, 0, 1, 12'h000, 0, 1, 0, 1, 16'h0005, 6'h00, 1);
    add(0, 8'h00, 0, 0, 0, 12'h000, 0, 1, 0, 1, 16'h0005, 6'h00, 1);
    add(0, 8'h00, 0, 0, 1, 12'h001, 0, 0, 0, 0, 16'h0005, 6'h00, 1);
    add(1, 8'h77, 0, 0, 1, 12'h001, 1, 0, 0, 0, 16'h0005, 6'h00, 1);
    add(1, 8'h88, 0, 0, 1, 12'h002, 1, 0, 0, 0, 16'h0077, 6'h00, 1);
    add(0, 8'h00, 0, 0, 1, 12'h004, 0, 1, 1, 0, 16'h8877, 6'h00, 1);
    add(0, 8'h00, 0, 1, 1, 12'h008, 0, 1, 0, 0, 16'h8877, 6'h22, 1);
    add(0, 8'h00, 0, 0, 0, 12'h000, 0, 1, 0, 1, 16'h8877, 6'h22, 1);
    add(1, 8'h9A, 0, 0, 0, 12'h001, 1, 0, 0, 0, 16'h8877, 6'h22, 1);

    Reset = 1'b1; Mem_Ready = 1'b1; Mem_Data = 8'h5A; Stall = 1'b0; Done = 1'b0; Halt = 1'b0;
    rst3 = 1'b1; mr3 = 1'b0; md3 = 8'h00; st3 = 1'b0; dn3 = 1'b0; hl3 = 1'b0;

    repeat (2) @(negedge Clock);
    #1;
    check("reset T", 32'(T), 32'h001);
    check("reset IR", 32'(IR), 32'h0);
    check("reset Opcode", 32'(Opcode), 32'h0);
    check("reset Mem_CS", 32'(Mem_CS), 32'h1);
    check("reset PC_Inc", 32'(PC_Inc), 32'h0);
    check("reset Decode_Valid", 32'(Decode_Valid), 32'h0);
    check("reset Halted", 32'(Halted), 32'h0);
    check("reset Overrun", 32'(Overrun), 32'h0);
    Mem_Ready = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      @(negedge Clock);
      Mem_Ready = vecs[i].mr; Mem_Data = vecs[i].md;
      Stall = vecs[i].st; Done = vecs[i].dn; Halt = vecs[i].hl;
      #1;
      check($sformatf("v%0d T", i), 32'(T), 32'(vecs[i].t));
      check($sformatf("v%0d PC_Inc", i), 32'(PC_Inc), 32'(vecs[i].pc));
      check($sformatf("v%0d Mem_CS", i), 32'(Mem_CS), 32'(vecs[i].cs));
      check($sformatf("v%0d Decode_Valid", i), 32'(Decode_Valid), 32'(vecs[i].dv));
      check($sformatf("v%0d Halted", i), 32'(Halted), 32'(vecs[i].hd));
      check($sformatf("v%0d IR", i), 32'(IR), 32'(vecs[i].ir));
      check($sformatf("v%0d Opcode", i), 32'(Opcode), 32'(vecs[i].op));
      check($sformatf("v%0d Overrun", i), 32'(Overrun), 32'(vecs[i].ov));
    end

    // asynchronous reset at T1 with a partially loaded IR
    @(negedge Clock);
    Mem_Ready = 1'b0; Done = 1'b0; Halt = 1'b0; Stall = 1'b0;
    #1;
    check("pre-reset T", 32'(T), 32'h002);
    check("pre-reset IR", 32'(IR), 32'h889A);
    #1;
    Reset = 1'b1; Mem_Ready = 1'b1;
    #1;
    check("async reset T", 32'(T), 32'h001);
    check("async reset IR", 32'(IR), 32'h0);
    check("async reset Overrun", 32'(Overrun), 32'h0);
    check("async reset Mem_CS", 32'(Mem_CS), 32'h1);
    check("async reset PC_Inc", 32'(PC_Inc), 32'h0);
    @(negedge Clock);
    Mem_Ready = 1'b0;
    Reset = 1'b0;

    // three-byte configuration
    @(negedge Clock);
    rst3 = 1'b0;
    pc_cnt = 0;
    @(negedge Clock);
    mr3 = 1'b1; md3 = 8'h56;
    #1;
    check("ib3 T0", 32'(t3), 32'h001);
    check("ib3 Mem_CS fetch", 32'(cs3), 32'h0);
    pc_cnt += int'(pc3);
    @(negedge Clock);
    md3 = 8'h34;
    #1;
    check("ib3 T1", 32'(t3), 32'h002);
    pc_cnt += int'(pc3);
    @(negedge Clock);
    md3 = 8'h12;
    #1;
    check("ib3 T2", 32'(t3), 32'h004);
    pc_cnt += int'(pc3);
    @(negedge Clock);
    mr3 = 1'b0; md3 = 8'hEE;
    #1;
    check("ib3 decode T", 32'(t3), 32'h008);
    check("ib3 Decode_Valid", 32'(dv3), 32'h1);
    check("ib3 IR", 32'(ir3), 32'h123456);
    pc_cnt += int'(pc3);
    @(negedge Clock);
    dn3 = 1'b1;
    #1;
    check("ib3 exec T", 32'(t3), 32'h010);
    check("ib3 Opcode", 32'(op3), 32'h04);
    pc_cnt += int'(pc3);
    @(negedge Clock);
    dn3 = 1'b0;
    #1;
    check("ib3 Done to T0", 32'(t3), 32'h001);
    check("ib3 PC_Inc pulses", 32'(pc_cnt), 32'd3);
    check("ib3 Halted", 32'(hd3), 32'h0);
    check("ib3 Overrun", 32'(ov3), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
